// File: rtl/pc_step_controller_pkg.sv
// Shared types and constants for the PC step controller.
package pc_step_controller_pkg;

  // Default sequential PC increment in bytes.
  localparam int unsigned INCR_DEFAULT = 4;

  // Encodings are visible on the LEDs, so the values are fixed.
  typedef enum logic [2:0] {
    S_PAUSE = 3'd0,
    S_STEP  = 3'd1,
    S_RUN   = 3'd2,
    S_HALT  = 3'd3
  } state_t;

  // A redirect target must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_step_controller_step_edge_detect.sv
// Rising-edge pulse from the debounced step button level.
module step_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic step_btn,
  output logic step_edge
);

  logic step_btn_q;

  // Remember last cycle's button level.
  always_ff @(posedge clock_in) begin
    if (reset) step_btn_q <= 1'b0;
    else       step_btn_q <= step_btn;
  end

  // One-cycle pulse on a 0->1 transition.
  always_comb begin
    step_edge = step_btn & ~step_btn_q;
  end

endmodule

// File: rtl/pc_step_controller.sv
// PC sequencing: run/step/pause/halt FSM, breakpoint, next-PC mux.
module pc_step_controller
  import pc_step_controller_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned INCR  = INCR_DEFAULT
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             bp_enable,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc_current,
  input  logic             stall,
  input  logic             halt_instr,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             jump,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             jr,
  input  logic [PC_W-1:0]  jr_target,
  output logic [PC_W-1:0]  pc_next,
  output logic             pc_write,
  output logic             pipe_flush,
  output logic [2:0]       state,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_edge;
  logic             redirect;
  logic             bp_hit;

  step_edge_detect u_step_edge (
    .clock_in  (clock_in),
    .reset     (reset),
    .step_btn  (step_btn),
    .step_edge (step_edge)
  );

  // Registered state, sticky misalignment flag and retired counter.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= S_PAUSE;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  // Next-PC select, FSM transitions and PC load/flush decode.
  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    pc_write   = 1'b0;
    pipe_flush = 1'b0;
    redirect   = jr | jump | branch_taken;
    bp_hit     = bp_enable && (pc_current == bp_addr);

    if (jr)                pc_next = jr_target;
    else if (jump)         pc_next = jump_target;
    else if (branch_taken) pc_next = branch_target;
    else                   pc_next = pc_current + PC_W'(INCR);

    case (state_q)
      S_PAUSE: begin
        if (run_mode)       state_d = S_RUN;
        else if (step_edge) state_d = S_STEP;
      end
      S_STEP, S_RUN: begin
        if (!stall) begin
          // Breakpoint and pause only apply while running, so a step can leave a bp.
          if (halt_instr) begin
            state_d = S_HALT;
          end else if (state_q == S_RUN && (bp_hit || !run_mode)) begin
            state_d = S_PAUSE;
          end else if (redirect && is_misaligned(pc_next[1:0])) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_write   = 1'b1;
            pipe_flush = redirect;
            if (state_q == S_STEP) state_d = S_PAUSE;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_PAUSE;
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      pipe_flush = 1'b0;
    end

    if (pc_write && count_q != '1) count_d = count_q + 1'b1;
  end

  // Registered status outputs.
  always_comb begin
    state        = state_q;
    halted       = (state_q == S_HALT);
    misalign_err = misalign_q;
    instr_count  = count_q;
  end

endmodule

// File: tb/tb_pc_step_controller.sv
// Directed scenarios plus random stimulus against a behavioural model.
module tb_pc_step_controller;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 2;

  logic              clock_in = 1'b0;
  logic              reset, run_mode, step_btn, bp_enable, stall, halt_instr;
  logic              branch_taken, jump, jr;
  logic [PC_W-1:0]   bp_addr, pc_current, branch_target, jump_target, jr_target;
  logic [PC_W-1:0]   pc_next;
  logic              pc_write, pipe_flush, halted, misalign_err;
  logic [2:0]        state;
  logic [CNT_W-1:0]  instr_count;

  int ntests = 0;
  int nfail  = 0;
  int writes_seen = 0;

  // Model: mode is the LED code (0 pause, 1 step, 2 run, 3 halt).
  int m_mode  = 0;
  bit m_prev  = 1'b0;
  bit m_mis   = 1'b0;
  int m_count = 0;

  always #5 clock_in = ~clock_in;

  pc_step_controller #(.PC_W(PC_W), .CNT_W(CNT_W), .INCR(4)) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .run_mode      (run_mode),
    .step_btn      (step_btn),
    .bp_enable     (bp_enable),
    .bp_addr       (bp_addr),
    .pc_current    (pc_current),
    .stall         (stall),
    .halt_instr    (halt_instr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .pipe_flush    (pipe_flush),
    .state         (state),
    .halted        (halted),
    .misalign_err  (misalign_err),
    .instr_count   (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; run_mode = 1'b0; step_btn = 1'b0; bp_enable = 1'b0; stall = 1'b0;
    halt_instr = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    bp_addr = '0; pc_current = '0; branch_target = '0; jump_target = '0; jr_target = '0;
  endtask

  // Called just after a falling edge with inputs applied: check, clock, advance model.
  task automatic tick();
    logic [31:0] tgt;
    bit redir, stp, w;
    int nmode, ncount;
    bit nmis;
    #1;
    redir  = jr | jump | branch_taken;
    tgt    = jr ? jr_target : jump ? jump_target : branch_taken ? branch_target
           : pc_current + 32'd4;
    stp    = step_btn && !m_prev;
    w      = 1'b0;
    nmode  = m_mode;
    nmis   = m_mis;
    ncount = m_count;
    if (reset) begin
      nmode = 0; nmis = 1'b0; ncount = 0;
    end else if (m_mode == 0) begin
      if (run_mode) nmode = 2;
      else if (stp) nmode = 1;
    end else if ((m_mode == 1 || m_mode == 2) && !stall) begin
      if (halt_instr) nmode = 3;
      else if (m_mode == 2 && bp_enable && pc_current == bp_addr) nmode = 0;
      else if (m_mode == 2 && !run_mode) nmode = 0;
      else if (redir && (tgt % 4) != 0) begin nmis = 1'b1; nmode = 3; end
      else begin
        w = 1'b1;
        if (m_mode == 1) nmode = 0;
        ncount = (m_count == 3) ? 3 : m_count + 1;
      end
    end
    chk("state",        32'(state),        32'(m_mode));
    chk("halted",       32'(halted),       32'(m_mode == 3));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("instr_count",  32'(instr_count),  32'(m_count));
    chk("pc_write",     32'(pc_write),     32'(w));
    chk("pipe_flush",   32'(pipe_flush),   32'(w && redir));
    if (w) chk("pc_next", pc_next, tgt);
    if (pc_write === 1'b1) writes_seen++;
    @(posedge clock_in);
    m_mode  = nmode;
    m_mis   = nmis;
    m_count = ncount;
    m_prev  = reset ? 1'b0 : step_btn;
    @(negedge clock_in);
  endtask

  initial begin
    int w0;
    idle();
    reset    = 1'b1;
    run_mode = 1'b1;
    @(negedge clock_in);
    @(negedge clock_in);
    // Reset cycle: no write even with run_mode high.
    tick();
    reset = 1'b0; run_mode = 1'b0;

    // 1: three step edges from PAUSE at pc 0.
    w0 = writes_seen;
    repeat (3) begin
      step_btn = 1'b1; tick();
      step_btn = 1'b0; tick(); tick();
    end
    chk("t1_writes", 32'(writes_seen - w0), 32'd3);
    chk("t1_count",  32'(instr_count), 32'd3);

    // 2: breakpoint hit in RUN, then step off it.
    pc_current = 32'h10; bp_enable = 1'b1; bp_addr = 32'h10; run_mode = 1'b1;
    tick(); tick();
    chk("t2_bp_pause", 32'(state), 32'd0);
    run_mode = 1'b0; w0 = writes_seen;
    step_btn = 1'b1; tick();
    step_btn = 1'b0; tick(); tick();
    chk("t2_step_writes", 32'(writes_seen - w0), 32'd1);
    bp_enable = 1'b0;

    // 3: jr beats jump and branch in the same cycle.
    run_mode = 1'b1; tick();
    pc_current = 32'h20; jr = 1'b1; jr_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
    branch_taken = 1'b1; branch_target = 32'hC0;
    #1;
    chk("t3_pc_next", pc_next, 32'h40);
    chk("t3_flush",   32'(pipe_flush), 32'd1);
    tick();
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;

    // 4: stalled RUN, then halt; run_mode/step have no effect afterwards.
    w0 = writes_seen; stall = 1'b1;
    repeat (4) tick();
    chk("t4_stall_writes", 32'(writes_seen - w0), 32'd0);
    stall = 1'b0; halt_instr = 1'b1; tick();
    halt_instr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_mode = i[0]; step_btn = i[1]; tick();
    end
    chk("t4_halted", 32'(halted), 32'd1);

    // 5: misaligned jump halts with sticky error; reset clears it.
    reset = 1'b1; tick(); reset = 1'b0;
    run_mode = 1'b1; step_btn = 1'b0; tick();
    jump = 1'b1; jump_target = 32'h102; tick();
    chk("t5_misalign", 32'(misalign_err), 32'd1);
    jump = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0; run_mode = 1'b0;
    chk("t5_reset_mis",   32'(misalign_err), 32'd0);
    chk("t5_reset_state", 32'(state), 32'd0);

    // 6: sequential wrap, and counter saturation at CNT_W=2.
    run_mode = 1'b1; tick();
    pc_current = 32'hFFFF_FFFC;
    #1;
    chk("t6_wrap", pc_next, 32'h0);
    repeat (5) tick();
    chk("t6_sat", 32'(instr_count), 32'd3);

    // Random phase.
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 29) == 0);
      run_mode     = ($urandom_range(0, 3) != 0);
      step_btn     = $urandom_range(0, 1) == 1;
      stall        = ($urandom_range(0, 3) == 0);
      halt_instr   = ($urandom_range(0, 39) == 0);
      pc_current   = {$urandom_range(0, 63), 2'b00};
      bp_enable    = $urandom_range(0, 1) == 1;
      bp_addr      = ($urandom_range(0, 3) == 0) ? pc_current : {$urandom_range(0, 63), 2'b00};
      jr           = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      jr_target     = {$urandom_range(0, 4095), 2'($urandom_range(0, 7) == 0 ? 1 : 0)};
      jump_target   = {$urandom_range(0, 4095), 2'($urandom_range(0, 7) == 0 ? 2 : 0)};
      branch_target = {$urandom_range(0, 4095), 2'($urandom_range(0, 7) == 0 ? 3 : 0)};
      if (n % 100 == 99) begin run_mode = 1'b0; pc_current = 32'hFFFF_FFFC; end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
